// File: rtl/ram_arbiter.sv
// Two-master (A=CPU, B=loader) round-robin arbiter with lock, in front of a single-port sync RAM.
// Ack is combinational in the grant cycle; read data returns 1 clk later; losers are held off by withholding ack.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic                  a_lock,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_ack,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic                  b_lock,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_ack,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_we,
  output logic                  ram_re,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_A = 2'd1, OWN_B = 2'd2} own_t;

  logic last_gnt;  // 0 = A, 1 = B
  own_t lock_own;
  own_t rd_tag;

  logic a_elig, b_elig, gnt_a, gnt_b;

  always_comb begin
    a_elig = a_req & (lock_own != OWN_B);
    b_elig = b_req & (lock_own != OWN_A);
    // Both eligible only happens when unlocked; the master not served last wins.
    gnt_a  = ~reset & a_elig & (~b_elig | last_gnt);
    gnt_b  = ~reset & b_elig & ~gnt_a;
  end

  always_comb begin
    a_ack    = gnt_a;
    b_ack    = gnt_b;
    ram_addr = '0;
    ram_din  = '0;
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    if (gnt_a) begin
      ram_addr = a_addr;
      ram_din  = a_wdata;
      ram_we   = a_we;
      ram_re   = ~a_we;
    end else if (gnt_b) begin
      ram_addr = b_addr;
      ram_din  = b_wdata;
      ram_we   = b_we;
      ram_re   = ~b_we;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt <= 1'b1;
      lock_own <= OWN_NONE;
      rd_tag   <= OWN_NONE;
    end else begin
      if (gnt_a && !a_we)      rd_tag <= OWN_A;
      else if (gnt_b && !b_we) rd_tag <= OWN_B;
      else                     rd_tag <= OWN_NONE;

      if (gnt_a) begin
        last_gnt <= 1'b0;
        lock_own <= a_lock ? OWN_A : OWN_NONE;
      end else if (gnt_b) begin
        last_gnt <= 1'b1;
        lock_own <= b_lock ? OWN_B : OWN_NONE;
      end else if ((lock_own == OWN_A && !a_req) || (lock_own == OWN_B && !b_req)) begin
        // An idle owner gives up the lock so the other master cannot starve.
        lock_own <= OWN_NONE;
      end
    end
  end

  assign a_rvalid = (rd_tag == OWN_A);
  assign b_rvalid = (rd_tag == OWN_B);
  assign a_rdata  = ram_dout;
  assign b_rdata  = ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM plus a rule-level reference model, directed then random traffic.
module tb_ram_arbiter;

  localparam int AW = 10;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset;
  logic a_req, a_we, a_lock, b_req, b_we, b_lock;
  logic [AW-1:0] a_addr, b_addr, ram_addr;
  logic [DW-1:0] a_wdata, b_wdata, ram_din, ram_dout, a_rdata, b_rdata;
  logic a_ack, b_ack, a_rvalid, b_rvalid, ram_we, ram_re;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_re(ram_re),
    .ram_dout(ram_dout)
  );

  // Generic single-port synchronous RAM
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    if (ram_re) ram_dout <= mem[ram_addr];
  end

  // Reference model: owners/winners encoded 0 = none, 1 = A, 2 = B
  int checks = 0;
  int errors = 0;
  int m_last = 2;
  int m_lock = 0;
  int m_rd   = 0;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic obs_a_ack, obs_b_ack, obs_a_rv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int winner(input bit rst, input bit ar, input bit br);
    if (rst) return 0;
    if (m_lock == 1) return ar ? 1 : 0;
    if (m_lock == 2) return br ? 2 : 0;
    if (ar && br) return (m_last == 1) ? 2 : 1;
    if (ar) return 1;
    if (br) return 2;
    return 0;
  endfunction

  task automatic go(input bit rst,
                    input bit ar, input bit aw, input bit al, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                    input bit br, input bit bw, input bit bl, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    int w;
    bit we, lk;
    logic [AW-1:0] ad_sel;
    logic [DW-1:0] d_sel;
    reset = rst;
    a_req = ar; a_we = aw; a_lock = al; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_lock = bl; b_addr = ba; b_wdata = bd;
    @(negedge clk);
    chk("a_rvalid", {31'd0, a_rvalid}, {31'd0, m_rd == 1});
    chk("b_rvalid", {31'd0, b_rvalid}, {31'd0, m_rd == 2});
    if (m_rd == 1) chk("a_rdata", {16'd0, a_rdata}, {16'd0, m_rdata});
    if (m_rd == 2) chk("b_rdata", {16'd0, b_rdata}, {16'd0, m_rdata});
    w = winner(rst, ar, br);
    we     = (w == 1) ? aw : bw;
    lk     = (w == 1) ? al : bl;
    ad_sel = (w == 1) ? aa : ba;
    d_sel  = (w == 1) ? ad : bd;
    chk("a_ack", {31'd0, a_ack}, {31'd0, w == 1});
    chk("b_ack", {31'd0, b_ack}, {31'd0, w == 2});
    if (w == 0)
      chk("ram_idle", {4'd0, ram_we, ram_re, ram_addr, ram_din}, 32'd0);
    else
      chk("ram_port", {4'd0, ram_we, ram_re, ram_addr, ram_din}, {4'd0, we, !we, ad_sel, d_sel});
    obs_a_ack = a_ack;
    obs_b_ack = b_ack;
    obs_a_rv  = a_rvalid;
    if (rst) begin
      m_rd = 0; m_lock = 0; m_last = 2;
    end else begin
      m_rd = (w != 0 && !we) ? w : 0;
      if (w != 0) begin
        if (we) ref_mem[ad_sel] = d_sel;
        else    m_rdata = ref_mem[ad_sel];
        m_last = w;
        m_lock = lk ? w : 0;
      end else if ((m_lock == 1 && !ar) || (m_lock == 2 && !br)) begin
        m_lock = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    go(1, 0,0,0,0,0, 0,0,0,0,0);
    go(1, 0,0,0,0,0, 0,0,0,0,0);
    // Fill addresses 0..15 through B so RAM and model agree
    for (int i = 0; i < 16; i++)
      go(0, 0,0,0,0,0, 1,1,0,AW'(i), (i == 5) ? 16'h1234 : DW'($urandom));

    // Single A read of 0x005
    go(0, 1,0,0,10'h005,0, 0,0,0,0,0);
    chk("single_a_ack", {31'd0, obs_a_ack}, 32'd1);
    go(0, 0,0,0,0,0, 0,0,0,0,0);
    chk("single_a_rv", {31'd0, obs_a_rv}, 32'd1);

    // Contention right after reset: A,B,A,B
    go(1, 0,0,0,0,0, 0,0,0,0,0);
    for (int i = 0; i < 4; i++) begin
      go(0, 1,0,0,10'h001,0, 1,0,0,10'h002,0);
      chk("alt_a", {31'd0, obs_a_ack}, {31'd0, (i % 2) == 0});
    end

    // B write then read at the top address
    go(0, 0,0,0,0,0, 1,1,0,10'h3FF,16'hBEEF);
    go(0, 0,0,0,0,0, 1,0,0,10'h3FF,0);
    go(0, 0,0,0,0,0, 0,0,0,0,0);

    // Lock: A locked read, A unlocking write, then B gets in
    go(0, 1,0,1,10'h003,0, 1,0,0,10'h004,0);
    chk("lock1_b", {31'd0, obs_b_ack}, 32'd0);
    go(0, 1,1,0,10'h003,16'h5A5A, 1,0,0,10'h004,0);
    chk("lock2_b", {31'd0, obs_b_ack}, 32'd0);
    go(0, 0,0,0,0,0, 1,0,0,10'h004,0);
    chk("lock3_b", {31'd0, obs_b_ack}, 32'd1);

    // Lock released by idling owner
    go(0, 1,0,1,10'h006,0, 1,0,0,10'h007,0);
    chk("idle1_a", {31'd0, obs_a_ack}, 32'd1);
    go(0, 0,0,0,0,0, 1,0,0,10'h007,0);
    chk("idle2_b", {31'd0, obs_b_ack}, 32'd0);
    go(0, 0,0,0,0,0, 1,0,0,10'h007,0);
    chk("idle3_b", {31'd0, obs_b_ack}, 32'd1);

    // Reset while A presents a locked read
    go(0, 0,0,0,0,0, 1,1,0,10'h008,16'h0F0F);
    go(1, 1,0,1,10'h005,0, 1,0,0,10'h006,0);
    go(0, 1,0,0,10'h005,0, 1,0,0,10'h006,0);
    chk("rst_rv", {31'd0, obs_a_rv}, 32'd0);
    chk("rst_first_a", {31'd0, obs_a_ack}, 32'd1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      go(($urandom % 64) == 0,
         ($urandom % 10) < 7, $urandom % 2, ($urandom % 10) < 3, AW'($urandom % 16), DW'($urandom),
         ($urandom % 10) < 7, $urandom % 2, ($urandom % 10) < 3, AW'($urandom % 16), DW'($urandom));
    end
    go(0, 0,0,0,0,0, 0,0,0,0,0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
